// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: state encoding and widths shared by the fetch sequencer and the instruction decoder
package fetch_sequencer_pkg;
    localparam int OPCODE_WIDTH = 4;
    localparam int PC_WIDTH_DEF = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_e;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches opcodes over a req/valid handshake and issues them one at a time
//   Build option: define FETCH_BREAKPOINT_EN to add the HALT state and the bp_en/bp_addr breakpoint.
//   Ports:
//     CLKin, nRESET          clock, asynchronous active-low reset
//     run, step              free-run level / single-step pulse
//     imem_req, imem_addr    fetch request and address (address = pc_out)
//     imem_valid, imem_data  memory response
//     instr_out, instr_valid instruction register and its one-cycle issue strobe
//     pc_out, busy, halted   program counter, FETCH/ISSUE indicator, breakpoint halt
//     bp_en, bp_addr         breakpoint control (only used with FETCH_BREAKPOINT_EN)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = OPCODE_WIDTH
) (
    input  logic                   CLKin,
    input  logic                   nRESET,
    input  logic                   run,
    input  logic                   step,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_valid,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic                   busy,
    output logic                   halted,
    input  logic                   bp_en,
    input  logic [PC_WIDTH-1:0]    bp_addr
);
    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   req_q, req_d, valid_q, valid_d, busy_q, busy_d;
    logic                   hit_idle, hit_issue;

    // Wraps silently at 2**PC_WIDTH.
    assign pc_inc = pc_q + PC_WIDTH'(1);

`ifdef FETCH_BREAKPOINT_EN
    logic halted_q, halted_d;
    // Breakpoint is checked against the address the next fetch would use.
    assign hit_idle  = bp_en && (pc_q == bp_addr);
    assign hit_issue = bp_en && (pc_inc == bp_addr);
    assign halted    = halted_q;
`else
    logic unused_bp;
    assign unused_bp = ^{bp_en, bp_addr};
    assign hit_idle  = 1'b0;
    assign hit_issue = 1'b0;
    assign halted    = 1'b0;
`endif

    always_ff @(posedge CLKin or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef FETCH_BREAKPOINT_EN
            halted_q <= halted_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_IDLE:  if (run || step) state_d = hit_idle ? ST_HALT : ST_FETCH;
            ST_FETCH: if (imem_valid) begin
                instr_d = imem_data;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                pc_d    = pc_inc;
                state_d = run ? (hit_issue ? ST_HALT : ST_FETCH) : ST_IDLE;
            end
`ifdef FETCH_BREAKPOINT_EN
            // Leaving HALT goes straight to FETCH so the breakpoint is skipped once.
            ST_HALT:  if (step) state_d = ST_FETCH;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output comes straight from a flop.
    always_comb begin
        req_d    = state_d == ST_FETCH;
        valid_d  = state_d == ST_ISSUE;
        busy_d   = req_d || valid_d;
`ifdef FETCH_BREAKPOINT_EN
        halted_d = state_d == ST_HALT;
`endif
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc_out      = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign busy        = busy_q;
endmodule
